logic_unit_pipe: RTL and testbench

//   Parametrised, two-stage pipelined bitwise logic unit with valid/ready handshake.

---
 rtl/logic_unit_pipe.sv | 113 +++++++++++
 tb/tb_logic_unit_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined 8-op bitwise logic unit with valid/ready handshake and flush.
// Optional statistics counters (op_count, stall_count) enabled by defining LOGIC_UNIT_STATS_EN.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  first_op,
  input  logic [WIDTH-1:0]  second_op,
  input  logic [FUNC_W-1:0] log_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  logic_o_data,
  output logic              zero_o,
  input  logic              flush
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [31:0]       op_count,
  output logic [15:0]       stall_count
`endif
);

  // Codes 000-011 keep the legacy 2-bit logic function encodings.
  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [FUNC_W-1:0] f);
    logic [WIDTH-1:0] r;
    case (f)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a | b);
      3'b011:  r = a ^ b;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]  a_p1, b_p1;
  logic [FUNC_W-1:0] func_p1;
  logic              vld_p1;
  logic [WIDTH-1:0]  res_p2;
  logic              zero_p2;
  logic              vld_p2;
  logic              adv_p1, adv_p2;
  logic [WIDTH-1:0]  res_p1;

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;
  assign res_p1   = logic_op(a_p1, b_p1, func_p1);

  // Stage 1: operand/opcode capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      func_p1 <= '0;
    end else begin
      if (flush)       vld_p1 <= 1'b0;
      else if (adv_p1) vld_p1 <= in_valid;
      if (adv_p1 && in_valid) begin
        a_p1    <= first_op;
        b_p1    <= second_op;
        func_p1 <= log_func;
      end
    end
  end

  // Stage 2: result and zero flag, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      zero_p2 <= 1'b0;
    end else begin
      if (flush)       vld_p2 <= 1'b0;
      else if (adv_p2) vld_p2 <= vld_p1;
      if (adv_p2 && vld_p1) begin
        res_p2  <= res_p1;
        zero_p2 <= (res_p1 == '0);
      end
    end
  end

  assign out_valid    = vld_p2;
  assign logic_o_data = res_p2;
  assign zero_o       = zero_p2;

`ifdef LOGIC_UNIT_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= 32'd0;
      stall_count <= 16'd0;
    end else begin
      if (out_valid && out_ready)  op_count    <= op_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= sat_inc16(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8): directed vectors, queue-based monitor.
// Statistics checks are compiled in when LOGIC_UNIT_STATS_EN is defined.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] first_op, second_op;
  logic [2:0]   log_func;
  logic         out_valid, out_ready;
  logic [W-1:0] logic_o_data;
  logic         zero_o;
  logic         flush;
`ifdef LOGIC_UNIT_STATS_EN
  logic [31:0]  op_count;
  logic [15:0]  stall_count;
`endif

  logic_unit_pipe #(.WIDTH(W), .FUNC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .first_op(first_op), .second_op(second_op), .log_func(log_func),
    .out_valid(out_valid), .out_ready(out_ready), .logic_o_data(logic_o_data),
    .zero_o(zero_o), .flush(flush)
`ifdef LOGIC_UNIT_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops on every output transfer and checks hold-stability during stalls.
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic         prev_zero;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall && out_valid) begin
        check("hold_data", 32'(logic_o_data), 32'(prev_data));
        check("hold_zero", 32'(zero_o), 32'(prev_zero));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, required no output", logic_o_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(logic_o_data), 32'(e.data));
          check("out_zero", 32'(zero_o), 32'(e.zero));
          if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = logic_o_data;
      prev_zero  = zero_o;
    end
  end

  // Present one op and wait (bounded) for it to be accepted; returns 1ns after the accepting edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                       input logic [W-1:0] req, input logic req_zero, input bit chk_lat);
    exp_t e;
    bit   done = 0;
    first_op  = a;
    second_op = b;
    log_func  = f;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = req; e.zero = req_zero; e.acc_cyc = cyc; e.chk_lat = chk_lat;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0, required accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep_req [8] = '{8'h42, 8'hDB, 8'h24, 8'h99, 8'hBD, 8'h66, 8'h81, 8'hC3};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; first_op = '0; second_op = '0; log_func = '0;
    out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(logic_o_data), 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef LOGIC_UNIT_STATS_EN
    // Five ops, exactly three stalled edges while the first result waits.
    out_ready = 1'b0;
    drive(8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 0);
    drive(8'hF0, 8'h3C, 3'b001, 8'hFC, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(8'hF0, 8'h3C, 3'b011, 8'hCC, 1'b0, 0);
    drive(8'hF0, 8'h3C, 3'b111, 8'hF0, 1'b0, 0);
    drive(8'hF0, 8'h3C, 3'b110, 8'hC0, 1'b0, 0);
    drain();
    check("op_count_5", op_count, 32'd5);
    check("stall_count_3", 32'(stall_count), 32'd3);
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    drive(8'h01, 8'h01, 3'b000, 8'h01, 1'b0, 0);
    drain();
    check("op_count_wrap", op_count, 32'd0);
`endif

    // Op sweep, back-to-back with out_ready high
    for (int f = 0; f < 8; f++)
      drive(8'hC3, 8'h5A, 3'(f), sweep_req[f], 1'b0, 1);
    drain();

    // Zero flag
    drive(8'hA5, 8'hA5, 3'b011, 8'h00, 1'b1, 1);
    drive(8'hA5, 8'hA5, 3'b101, 8'hFF, 1'b0, 1);
    drain();

    // Back-pressure: two accepted, third refused until the output drains
    out_ready = 1'b0;
    drive(8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 0);
    drive(8'hF0, 8'h3C, 3'b001, 8'hFC, 1'b0, 0);
    first_op = 8'hF0; second_op = 8'h3C; log_func = 3'b011; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(logic_o_data), 32'h30);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    begin
      exp_t e;
      @(negedge clk);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      e.data = 8'hCC; e.zero = 1'b0; e.acc_cyc = cyc; e.chk_lat = 0;
      if (in_ready) exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    drain();

    // Flush with two ops in flight and a simultaneous input
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 3'b001, 8'h33, 1'b0, 0);
    drive(8'h11, 8'h22, 3'b011, 8'h33, 1'b0, 0);
    first_op = 8'h55; second_op = 8'hAA; log_func = 3'b001; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_late_out", 32'(out_valid), 32'd0);

    // Reset mid-stream with two ops in flight
    out_ready = 1'b0;
    drive(8'hFF, 8'h0F, 3'b000, 8'h0F, 1'b0, 0);
    drive(8'hFF, 8'h0F, 3'b001, 8'hFF, 1'b0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(logic_o_data), 32'd0);
    check("mid_rst_zero", 32'(zero_o), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Post-reset sanity op
    drive(8'h0F, 8'hFF, 3'b110, 8'h00, 1'b1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
